// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and arbitration states.
package dmem_arb_pkg;

    localparam int DMEM_ARB_NPORTS = 2;

    typedef logic [0:0] port_id_t;

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [DMEM_ARB_NPORTS-1:0] req_i,
    input  port_id_t                   last_i,
    output logic [DMEM_ARB_NPORTS-1:0] gnt_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DMEM_ARB_NPORTS; gi++) begin : g_pick
            assign gnt_o[gi] = req_i[gi] &&
                               (!req_i[DMEM_ARB_NPORTS-1-gi] || (last_i != port_id_t'(gi)));
        end
    endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded locking in front of the data memory.
// Optional conflict counter enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              lock_tmo,
    output logic [31:0]       perf_conflicts,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    logic [DMEM_ARB_NPORTS-1:0] req;
    logic [DMEM_ARB_NPORTS-1:0] we;
    logic [DMEM_ARB_NPORTS-1:0] lock;
    logic [DMEM_ARB_NPORTS-1:0] rr_gnt;
    logic [DMEM_ARB_NPORTS-1:0] gnt;

    arb_state_t     state_q, state_d;
    port_id_t       owner_q, owner_d;
    port_id_t       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           lock_tmo_c;

    logic [DMEM_ARB_NPORTS-1:0] rvalid_q;
    logic [DATA_W-1:0]          rdata_q [DMEM_ARB_NPORTS];

    assign req  = {req1, req0};
    assign we   = {we1, we0};
    assign lock = {lock1, lock0};

    rr_pick2 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        gnt        = '0;
        lock_tmo_c = 1'b0;
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (state_q == ARB_UNLOCKED) begin
            gnt = rr_gnt;
            for (int i = 0; i < DMEM_ARB_NPORTS; i++) begin
                if (gnt[i]) begin
                    last_d = port_id_t'(i);
                    if (lock[i]) begin
                        state_d = ARB_LOCKED;
                        owner_d = port_id_t'(i);
                        cnt_d   = '0;
                    end
                end
            end
        end else begin
            // The non-owner stalls even while the owner is idle.
            gnt[owner_q] = req[owner_q];
            cnt_d        = cnt_q + 1'b1;
            if (gnt[owner_q]) begin
                last_d = owner_q;
            end
            if (cnt_q == CNT_LAST) begin
                state_d    = ARB_UNLOCKED;
                cnt_d      = '0;
                last_d     = owner_q;
                lock_tmo_c = lock[owner_q];
            end else if (!lock[owner_q]) begin
                state_d = ARB_UNLOCKED;
                cnt_d   = '0;
            end
        end
        if (reset) begin
            gnt        = '0;
            lock_tmo_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_UNLOCKED;
            owner_q <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DMEM_ARB_NPORTS; gi++) begin : g_resp
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_q[gi] <= 1'b0;
                    rdata_q[gi]  <= '0;
                end else begin
                    rvalid_q[gi] <= gnt[gi] && !we[gi];
                    if (gnt[gi] && !we[gi]) begin
                        rdata_q[gi] <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign gnt0     = gnt[0];
    assign gnt1     = gnt[1];
    // A response registered just before reset must not escape during the reset cycle.
    assign rvalid0  = rvalid_q[0] && !reset;
    assign rvalid1  = rvalid_q[1] && !reset;
    assign rdata0   = rdata_q[0];
    assign rdata1   = rdata_q[1];
    assign lock_tmo = lock_tmo_c;

    assign mem_we    = gnt[1] ? we1 : (gnt[0] && we0);
    assign mem_addr  = gnt[1] ? addr1 : addr0;
    assign mem_wdata = gnt[1] ? wdata1 : wdata0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_q;
    logic        conflict;

    assign conflict = (req0 && req1) ||
                      ((state_q == ARB_LOCKED) && req[other_port(owner_q)]);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (conflict && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_conflicts = perf_q;
`else
    assign perf_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small data memory and a read-response scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, lock_tmo, mem_we;
    logic [31:0] rdata0, rdata1, perf_conflicts, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } resp_t;
    resp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .lock_tmo(lock_tmo),
        .perf_conflicts(perf_conflicts),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        resp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic resp_check();
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.port ? "rvalid1" : "rvalid0", e.port ? rvalid1 : rvalid0, 1);
            chk(e.port ? "rdata1" : "rdata0", e.port ? rdata1 : rdata0, e.data);
            chk("rvalid_other", e.port ? rvalid0 : rvalid1, 0);
            $display("resp port%0d data %0h", e.port, e.data);
        end else begin
            chk("rvalid0_idle", rvalid0, 0);
            chk("rvalid1_idle", rvalid1, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        resp_check();
    endtask

    task automatic idle_ports();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_ports();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_lock_tmo", lock_tmo, 0);
        chk("rst_perf", perf_conflicts, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_we, 0);
        reset = 1'b0;
        $display("reset done");
    endtask

    logic [31:0] perf_exp;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[1] = 32'd8;

        // 1: single read from port 0
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h4;
        #1;
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        push(0, 32'd8);
        tick();
        idle_ports();
        addr0 = 32'h44;
        #1;
        chk("t1_idle_addr", mem_addr, 32'h44);
        chk("t1_idle_we", mem_we, 0);
        tick();
        chk("t1_rdata_hold", rdata0, 32'd8);

        // 2: both ports held, alternating grants
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h4; addr1 = 32'h4;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t2_gnt0", gnt0, (c % 2 == 0) ? 1 : 0);
            chk("t2_gnt1", gnt1, (c % 2 == 1) ? 1 : 0);
            push((c % 2 == 1), 32'd8);
            $display("t2 cycle %0d gnt0=%0b gnt1=%0b", c, gnt0, gnt1);
            tick();
        end
`ifdef DMEM_ARB_PERF_EN
        perf_exp = 32'd4;
`else
        perf_exp = 32'd0;
`endif
        chk("t2_perf", perf_conflicts, perf_exp);
        idle_ports();
        tick();

        // 3: locked write/read on port 1 stalls port 0
        do_reset();
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h10; wdata1 = 32'h2A;
        #1;
        chk("t3_wr_gnt1", gnt1, 1);
        chk("t3_wr_mem_we", mem_we, 1);
        tick();
        we1 = 0; req0 = 1; addr0 = 32'h4;
        #1;
        chk("t3_rd_gnt1", gnt1, 1);
        chk("t3_rd_gnt0", gnt0, 0);
        push(1, 32'h2A);
        tick();
        req1 = 0; lock1 = 0;
        #1;
        chk("t3_stall_gnt0", gnt0, 0);
        tick();
        #1;
        chk("t3_release_gnt0", gnt0, 1);
        push(0, 32'd8);
        tick();
`ifdef DMEM_ARB_PERF_EN
        perf_exp = 32'd2;
`else
        perf_exp = 32'd0;
`endif
        chk("t3_perf", perf_conflicts, perf_exp);
        idle_ports();
        tick();

        // 4: lock timeout after MAX_LOCK cycles
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 32'h4;
        req1 = 1; addr1 = 32'h4;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t4_gnt0", gnt0, (c < 9) ? 1 : 0);
            chk("t4_gnt1", gnt1, (c == 9) ? 1 : 0);
            chk("t4_lock_tmo", lock_tmo, (c == 8) ? 1 : 0);
            push((c == 9), 32'd8);
            $display("t4 cycle %0d gnt0=%0b gnt1=%0b tmo=%0b", c, gnt0, gnt1, lock_tmo);
            tick();
        end
        idle_ports();
        tick();

        // 5: reset right after an accepted locked read
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 32'h4;
        #1;
        chk("t5_gnt1", gnt1, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_ports();
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55;
        #1;
        chk("t5_rst_rvalid1", rvalid1, 0);
        chk("t5_rst_mem_we", mem_we, 0);
        chk("t5_rst_lock_tmo", lock_tmo, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_ports();
        chk("t5_post_rvalid1", rvalid1, 0);
        chk("t5_no_write", mem[8], 0);
        req0 = 1; req1 = 1; addr0 = 32'h4; addr1 = 32'h4;
        #1;
        chk("t5_tie_gnt0", gnt0, 1);
        chk("t5_tie_gnt1", gnt1, 0);
        push(0, 32'd8);
        tick();
        idle_ports();
        tick();

        // 6: same-cycle write then read of one address
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'h0; wdata0 = 32'hDEAD;
        req1 = 1; we1 = 0; addr1 = 32'h0;
        #1;
        chk("t6_gnt0", gnt0, 1);
        chk("t6_gnt1", gnt1, 0);
        chk("t6_mem_we", mem_we, 1);
        chk("t6_mem_wdata", mem_wdata, 32'hDEAD);
        tick();
        idle_ports();
        req1 = 1; addr1 = 32'h0;
        #1;
        chk("t6_rd_gnt1", gnt1, 1);
        push(1, 32'hDEAD);
        tick();
        idle_ports();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
